// File: rtl/rfid_link_timing_ctrl.sv
// Reader-side link-timing sequencer: reply wait (T1), tag frame reception and
// reader turnaround windows, driving a shared down-count timer.
module rfid_link_timing_ctrl #(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned MIN_LOAD  = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CmdDone,
    input  logic        ReplyExpected,
    input  logic        RxPreambleDet,
    input  logic        RxDone,
    input  logic        RxCrcErr,
    input  logic        Abort,
    input  logic [15:0] T1Max,
    input  logic [15:0] FrameMax,
    input  logic [15:0] TurnMin,
    input  logic        TimedOut,
    output logic [15:0] TimerIn,
    output logic        TimerStart,
    output logic        TxReady,
    output logic        Busy,
    output logic        ReplyOk,
    output logic        ReplyErr,
    output logic        NoReply,
    output logic        RetryReq,
    output logic [3:0]  RetryCnt,
    output logic [2:0]  DbgState
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_REPLY,
        S_RX_FRAME,
        S_TURNAROUND
    } stateT;

    localparam logic [15:0] MinLoad  = 16'(MIN_LOAD);
    localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);

    stateT       state;
    stateT       armTarget;
    logic        armReq;
    stateT       armTo;
    logic [15:0] armSrc;

    function automatic logic [15:0] clampLoad(input logic [15:0] v);
        return (v < MinLoad) ? MinLoad : v;
    endfunction

    assign DbgState = state;

    // Timer protocol: TimerIn is loaded in the ARM cycle while TimerStart is
    // low, so every window starts with a fresh load on the next rising edge of
    // TimerStart; TimedOut is only honoured while a timed state holds it high.
    always_comb begin
        armReq = 1'b0;
        armTo  = S_TURNAROUND;
        armSrc = TurnMin;
        case (state)
            S_IDLE: begin
                if (CmdDone) begin
                    armReq = 1'b1;
                    if (ReplyExpected) begin
                        armTo  = S_WAIT_REPLY;
                        armSrc = T1Max;
                    end
                end
            end
            S_WAIT_REPLY: begin
                if (RxPreambleDet) begin
                    armReq = 1'b1;
                    armTo  = S_RX_FRAME;
                    armSrc = FrameMax;
                end else if (TimedOut && (RetryCnt >= MaxRetry)) begin
                    armReq = 1'b1;
                end
            end
            S_RX_FRAME: begin
                if (RxDone || TimedOut) begin
                    armReq = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            armTarget  <= S_IDLE;
            TimerIn    <= '0;
            TimerStart <= 1'b0;
            TxReady    <= 1'b1;
            Busy       <= 1'b0;
            ReplyOk    <= 1'b0;
            ReplyErr   <= 1'b0;
            NoReply    <= 1'b0;
            RetryReq   <= 1'b0;
            RetryCnt   <= '0;
        end else begin
            ReplyOk  <= 1'b0;
            ReplyErr <= 1'b0;
            NoReply  <= 1'b0;
            RetryReq <= 1'b0;
            if (Abort) begin
                state      <= S_IDLE;
                TimerStart <= 1'b0;
                TxReady    <= 1'b1;
                Busy       <= 1'b0;
                RetryCnt   <= '0;
            end else begin
                case (state)
                    S_ARM: begin
                        state      <= armTarget;
                        TimerStart <= 1'b1;
                    end
                    S_WAIT_REPLY: begin
                        if (!RxPreambleDet && TimedOut) begin
                            if (RetryCnt < MaxRetry) begin
                                RetryReq   <= 1'b1;
                                RetryCnt   <= RetryCnt + 4'd1;
                                state      <= S_IDLE;
                                TimerStart <= 1'b0;
                                TxReady    <= 1'b1;
                                Busy       <= 1'b0;
                            end else begin
                                NoReply  <= 1'b1;
                                RetryCnt <= '0;
                            end
                        end
                    end
                    S_RX_FRAME: begin
                        if (RxDone) begin
                            if (RxCrcErr) begin
                                ReplyErr <= 1'b1;
                            end else begin
                                ReplyOk  <= 1'b1;
                                RetryCnt <= '0;
                            end
                        end else if (TimedOut) begin
                            ReplyErr <= 1'b1;
                        end
                    end
                    S_TURNAROUND: begin
                        if (TimedOut) begin
                            state      <= S_IDLE;
                            TimerStart <= 1'b0;
                            TxReady    <= 1'b1;
                            Busy       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
                // Any window change passes through ARM with the timer stopped.
                if (armReq) begin
                    state      <= S_ARM;
                    armTarget  <= armTo;
                    TimerIn    <= clampLoad(armSrc);
                    TimerStart <= 1'b0;
                    Busy       <= 1'b1;
                    TxReady    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rfid_link_timing_ctrl.sv
// Bench for rfid_link_timing_ctrl: timer environment, directed scenarios,
// randomized traffic, and a behavioural transaction model checked every cycle.
`timescale 1ns/1ps
module tb_rfid_link_timing_ctrl;
    localparam int MAXR = 3;
    localparam int MINL = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_RX   = 3;
    localparam int PH_TURN = 4;

    localparam logic [3:0] EV_OK  = 4'b1000;
    localparam logic [3:0] EV_ERR = 4'b0100;
    localparam logic [3:0] EV_NOR = 4'b0010;
    localparam logic [3:0] EV_RR  = 4'b0001;

    localparam int SEL_RR = 0, SEL_NOR = 1, SEL_OK = 2, SEL_ERR = 3, SEL_TXR = 4;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Reset;
    logic        CmdDone, ReplyExpected, RxPreambleDet, RxDone, RxCrcErr, Abort;
    logic [15:0] T1Max, FrameMax, TurnMin;
    logic        TimedOut;
    logic [15:0] TimerIn;
    logic        TimerStart, TxReady, Busy, ReplyOk, ReplyErr, NoReply, RetryReq;
    logic [3:0]  RetryCnt;
    logic [2:0]  dbgState;

    always #5 Clk = ~Clk;

    rfid_link_timing_ctrl #(.MAX_RETRY(MAXR), .MIN_LOAD(MINL)) dut (
        .Clk(Clk), .Reset(Reset), .CmdDone(CmdDone), .ReplyExpected(ReplyExpected),
        .RxPreambleDet(RxPreambleDet), .RxDone(RxDone), .RxCrcErr(RxCrcErr),
        .Abort(Abort), .T1Max(T1Max), .FrameMax(FrameMax), .TurnMin(TurnMin),
        .TimedOut(TimedOut), .TimerIn(TimerIn), .TimerStart(TimerStart),
        .TxReady(TxReady), .Busy(Busy), .ReplyOk(ReplyOk), .ReplyErr(ReplyErr),
        .NoReply(NoReply), .RetryReq(RetryReq), .RetryCnt(RetryCnt),
        .DbgState(dbgState)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, m_after, m_retry;
    logic [15:0] m_load;
    logic [3:0]  m_pulse;
    logic [3:0]  exp_q[$];

    task automatic open_window(input int target, input logic [15:0] v);
        m_phase = PH_ARM;
        m_after = target;
        m_load  = (v < 16'(MINL)) ? 16'(MINL) : v;
    endtask

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase = PH_IDLE;
            m_after = PH_IDLE;
            m_retry = 0;
            m_load  = '0;
            m_pulse = '0;
            exp_q.delete();
        end else begin
            m_pulse = '0;
            if (Abort) begin
                m_phase = PH_IDLE;
                m_retry = 0;
            end else if (m_phase == PH_IDLE && CmdDone) begin
                if (ReplyExpected) open_window(PH_WAIT, T1Max);
                else               open_window(PH_TURN, TurnMin);
            end else if (m_phase == PH_ARM) begin
                m_phase = m_after;
            end else if (m_phase == PH_WAIT && RxPreambleDet) begin
                open_window(PH_RX, FrameMax);
            end else if (m_phase == PH_WAIT && TimedOut) begin
                if (m_retry < MAXR) begin
                    m_pulse = EV_RR;
                    m_retry = m_retry + 1;
                    m_phase = PH_IDLE;
                end else begin
                    m_pulse = EV_NOR;
                    m_retry = 0;
                    open_window(PH_TURN, TurnMin);
                end
            end else if (m_phase == PH_RX && (RxDone || TimedOut)) begin
                if (RxDone && !RxCrcErr) begin
                    m_pulse = EV_OK;
                    m_retry = 0;
                end else begin
                    m_pulse = EV_ERR;
                end
                open_window(PH_TURN, TurnMin);
            end else if (m_phase == PH_TURN && TimedOut) begin
                m_phase = PH_IDLE;
            end
            if (m_pulse != 0) exp_q.push_back(m_pulse);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge Clk) begin
        if (!Reset) begin
            logic [3:0] pulses;
            pulses = {ReplyOk, ReplyErr, NoReply, RetryReq};
            chk("TimerStart", TimerStart, m_phase >= PH_WAIT);
            chk("TxReady", TxReady, m_phase == PH_IDLE);
            chk("Busy", Busy, m_phase != PH_IDLE);
            chk("TimerIn", TimerIn, m_load);
            chk("RetryCnt", RetryCnt, m_retry);
            chk("Pulses", pulses, m_pulse);
            chk("StateKnown", ^dbgState === 1'bx, 0);
            if (pulses != 0) begin
                if (exp_q.size() == 0) chk("EventOrder", pulses, 0);
                else                   chk("EventOrder", pulses, exp_q.pop_front());
            end
        end
    end

    // ---------------- timer environment + driver tasks ----------------
    logic tmr_prev = 1'b0;
    int   tmr_el   = 0;
    int   tmr_load = 0;

    task automatic next_cycle();
        @(negedge Clk);
        CmdDone       = 1'b0;
        RxPreambleDet = 1'b0;
        RxDone        = 1'b0;
        RxCrcErr      = 1'b0;
        Abort         = 1'b0;
        if (TimerStart === 1'b1) begin
            if (!tmr_prev) begin
                tmr_el   = 0;
                tmr_load = int'(TimerIn);
            end else begin
                tmr_el++;
            end
        end
        tmr_prev = (TimerStart === 1'b1);
        TimedOut = tmr_prev && (tmr_el >= tmr_load - 1);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_RR:  return RetryReq;
            SEL_NOR: return NoReply;
            SEL_OK:  return ReplyOk;
            SEL_ERR: return ReplyErr;
            default: return TxReady;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            next_cycle();
            if (sig(sel) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic send_cmd(input logic re);
        next_cycle();
        CmdDone       = 1'b1;
        ReplyExpected = re;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int c, p, n, at;
        CmdDone = 0; ReplyExpected = 0; RxPreambleDet = 0; RxDone = 0; RxCrcErr = 0;
        Abort = 0; TimedOut = 0; T1Max = 10; FrameMax = 50; TurnMin = 5;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        next_cycle();
        chk("ResetTxReady", TxReady, 1);
        chk("ResetBusy", Busy, 0);
        chk("ResetTimerIn", TimerIn, 0);
        chk("ResetTimerStart", TimerStart, 0);
        chk("ResetRetryCnt", RetryCnt, 0);

        // No reply with T1Max=10: retry pulse 12 cycles after CmdDone
        T1Max = 10;
        send_cmd(1'b1); c = cyc;
        next_cycle();
        chk("S1ArmTimerIn", TimerIn, 10);
        chk("S1ArmStart", TimerStart, 0);
        next_cycle();
        chk("S1WaitStart", TimerStart, 1);
        wait_for(SEL_RR, 30, "S1RetryWait", at);
        chk("S1RetryLatency", at - c, 12);
        chk("S1RetryCnt", RetryCnt, 1);
        chk("S1TxReady", TxReady, 1);

        // Two more retries, then NoReply and a TurnMin=5 turnaround
        for (int i = 0; i < 2; i++) begin
            send_cmd(1'b1);
            wait_for(SEL_RR, 30, "S2RetryWait", at);
            chk("S2RetryCnt", RetryCnt, i + 2);
        end
        TurnMin = 5;
        send_cmd(1'b1);
        wait_for(SEL_NOR, 30, "S2NoReplyWait", n);
        chk("S2NoReplyCnt", RetryCnt, 0);
        chk("S2ArmTurnLoad", TimerIn, 5);
        wait_for(SEL_TXR, 30, "S2TurnWait", at);
        chk("S2TurnLatency", at - n, 6);

        // Good frame: preamble, 50-cycle frame window, then TurnMin=7
        T1Max = 40; FrameMax = 50; TurnMin = 7;
        send_cmd(1'b1); c = cyc;
        repeat (5) next_cycle();
        RxPreambleDet = 1'b1;
        next_cycle();
        chk("S3GapStart", TimerStart, 0);
        chk("S3FrameLoad", TimerIn, 50);
        next_cycle();
        chk("S3FrameStart", TimerStart, 1);
        next_cycle();
        FrameMax = 3;
        next_cycle();
        chk("S3FrameHeld", TimerIn, 50);
        repeat (5) next_cycle();
        RxDone = 1'b1;
        next_cycle();
        chk("S3ReplyOk", ReplyOk, 1);
        chk("S3OkCnt", RetryCnt, 0);
        chk("S3TurnLoad", TimerIn, 7);
        chk("S3TurnGap", TimerStart, 0);
        next_cycle();
        chk("S3OkSingle", ReplyOk, 0);
        chk("S3TurnStart", TimerStart, 1);
        wait_for(SEL_TXR, 40, "S3TurnWait", at);

        // CRC error and frame timeout leave RetryCnt alone
        T1Max = 4;
        send_cmd(1'b1);
        wait_for(SEL_RR, 30, "S4RetryWait", at);
        T1Max = 30; FrameMax = 50;
        send_cmd(1'b1);
        repeat (3) next_cycle();
        RxPreambleDet = 1'b1;
        repeat (3) next_cycle();
        RxDone = 1'b1; RxCrcErr = 1'b1;
        next_cycle();
        chk("S4CrcErr", ReplyErr, 1);
        chk("S4CrcNoOk", ReplyOk, 0);
        chk("S4CrcCnt", RetryCnt, 1);
        wait_for(SEL_TXR, 40, "S4TurnWait", at);
        FrameMax = 8;
        send_cmd(1'b1);
        repeat (3) next_cycle();
        RxPreambleDet = 1'b1; p = cyc;
        wait_for(SEL_ERR, 30, "S4FrameTimeout", at);
        chk("S4FrameLatency", at - p, 10);
        chk("S4FrameCnt", RetryCnt, 1);
        wait_for(SEL_TXR, 40, "S4TurnWait2", at);

        // T1Max clamped to 3; preamble wins over same-cycle TimedOut
        T1Max = 1; FrameMax = 20;
        send_cmd(1'b1);
        next_cycle();
        chk("S5Clamp", TimerIn, 3);
        repeat (3) next_cycle();
        RxPreambleDet = 1'b1;
        next_cycle();
        chk("S5NoRetry", RetryReq, 0);
        chk("S5FrameLoad", TimerIn, 20);
        chk("S5Busy", Busy, 1);
        next_cycle();
        chk("S5FrameStart", TimerStart, 1);
        next_cycle();
        RxDone = 1'b1;
        next_cycle();
        chk("S5ReplyOk", ReplyOk, 1);
        chk("S5OkCnt", RetryCnt, 0);
        wait_for(SEL_TXR, 40, "S5TurnWait", at);

        // Abort in RX_FRAME beats a same-cycle RxDone
        T1Max = 4;
        send_cmd(1'b1);
        wait_for(SEL_RR, 30, "S6RetryWait", at);
        T1Max = 30; FrameMax = 40;
        send_cmd(1'b1);
        repeat (3) next_cycle();
        RxPreambleDet = 1'b1;
        repeat (3) next_cycle();
        Abort = 1'b1; RxDone = 1'b1;
        next_cycle();
        chk("S6AbortTxReady", TxReady, 1);
        chk("S6AbortStart", TimerStart, 0);
        chk("S6AbortPulses", {ReplyOk, ReplyErr, NoReply, RetryReq}, 0);
        chk("S6AbortCnt", RetryCnt, 0);

        // CmdDone ignored in TURNAROUND, then asynchronous reset mid-window
        TurnMin = 20;
        send_cmd(1'b0);
        repeat (3) next_cycle();
        CmdDone = 1'b1; ReplyExpected = 1'b1; T1Max = 9;
        next_cycle();
        chk("S6IgnoreCmdStart", TimerStart, 1);
        chk("S6IgnoreCmdLoad", TimerIn, 20);
        next_cycle();
        #2 Reset = 1'b1;
        #1;
        chk("S6ResetStart", TimerStart, 0);
        chk("S6ResetTxReady", TxReady, 1);
        chk("S6ResetTimerIn", TimerIn, 0);
        next_cycle();
        Reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            if (m_phase != PH_ARM && $urandom_range(0, 7) == 0) begin
                T1Max    = 16'($urandom_range(0, 24));
                FrameMax = 16'($urandom_range(0, 24));
                TurnMin  = 16'($urandom_range(0, 24));
            end
            CmdDone       = ($urandom_range(0, 3) == 0);
            ReplyExpected = ($urandom_range(0, 3) != 0);
            RxPreambleDet = ($urandom_range(0, 5) == 0);
            RxDone        = ($urandom_range(0, 5) == 0);
            RxCrcErr      = 1'($urandom_range(0, 1));
            Abort         = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) TimedOut = 1'b1;
        end
        next_cycle();
        next_cycle();
        chk("EventQueueEmpty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
